fact_accel: RTL and testbench
=============================

# fact_accel

Memory-mapped iterative factorial accelerator for the single-cycle MIPS SoC. It sits on the data-memory bus beside the GPIO block, behind the system address decoder. Software writes an operand and a go command. An internal FSM then sequences a 32-bit multiply/decrement datapath until n! is ready. Software polls status or watches the `done` line, then reads the result.

## Interface
- `MAX_N`, 12: largest operand whose factorial fits in 32 bits; larger operands raise `err`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `a`  in  2  word-address select from the decoder: 0 = N, 1 = GO, 2 = STATUS, 3 = RESULT.
- `we`  in  1  write enable, already qualified by the decoder for this block.
- `wd`  in  32  write data from the CPU.
- `rd`  out  32  read data, combinational on `a`.
- `done`  out  1  mirrors STATUS bit 0, for GPO/polling.
- `busy`  out  1  high while the FSM is in MULT.

## Operation
- Registers:
  - N: 4 bits, written from `wd[3:0]` when `we` is high and `a` = 0. Reads as zero-extended.
  - GO: write-only trigger, `we` high and `a` = 1 and `wd[0]` = 1. Reads `{31'b0, busy}`.
  - STATUS: reads `{30'b0, err, done}`. Writes to it are ignored.
  - RESULT: 32 bits. Writes to it are ignored.
- FSM states:
  - IDLE: waits for a GO write.
    - GO with N ≤ `MAX_N`: load `cnt` ← N and `prod` ← 1, clear `done` and `err`, go to MULT.
    - GO with N > `MAX_N`: set `err` = 1, `done` = 1, RESULT ← 0, stay in IDLE.
  - MULT: evaluated every edge.
    - If `cnt` > 1: `prod` ← `prod` × `cnt` (low 32 bits), `cnt` ← `cnt` − 1.
    - Otherwise: RESULT ← `prod`, `done` ← 1, go to IDLE.
- `done` and `err` are sticky and clear only on the next accepted GO or on reset.
- GO while in MULT is ignored: no restart, no error.
- Writing N while in MULT updates the N register but does not affect the computation in flight.
- RESULT holds its last value until a computation completes or an `err` GO occurs.
- A GO write with `wd[0]` = 0 has no effect.

## Timing
- Reset (asynchronous, immediate): state IDLE; N, `cnt`, RESULT = 0; `prod` = 1; `done`, `err`, `busy` = 0; `rd` reflects these values.
- Let edge 0 be the rising edge at which the GO write is sampled.
  - Valid N: `busy` is high from after edge 0. RESULT is valid and `done` = 1 from after edge max(N,1), at which point `busy` drops.
  - N = 0 or N = 1: completes after edge 1 with RESULT = 1.
  - Err case: `err` = `done` = 1 after edge 0; `busy` never rises.
- A new GO is accepted at the same edge at which `done` becomes visible only if it falls one edge later. Back-to-back operation therefore needs at least one IDLE edge.
- `rst` asserted mid-MULT aborts at once, with no partial RESULT update.
- `rd` is purely combinational, so a read issued in the same cycle as a register update returns the pre-edge value.
- The multiply is one combinational 32×4 product per cycle; no multi-cycle paths.

## Test plan
- Reset, then read all four addresses -> `rd` = 0, 0, 0, 0; `done` = 0; `busy` = 0.
- Write N = 5, GO -> `busy` high for 5 cycles; after edge 5 `done` = 1, RESULT = 120 (0x78), STATUS = 0x1.
- N = 12, GO -> done after edge 12, RESULT = 479001600 (0x1C8CFC00). N = 0, GO -> done after edge 1, RESULT = 1.
- N = 13, GO -> STATUS = 0x3 after edge 0, RESULT = 0, `busy` never asserted. A following GO with N = 3 -> STATUS = 0x1, RESULT = 6.
- N = 6, GO, then at edge 2 write N = 2 and GO -> both ignored for the running job; RESULT = 720 after edge 6; N reads 2.
- N = 7, GO, assert `rst` between edges 3 and 4 -> all outputs return to reset values immediately; RESULT stays 0.

Source files
------------

// File: rtl/fact_if.sv
// fact_accel data-memory bus bundle.
// CPU side drives a/we/wd; accelerator drives rd/done/busy.
interface fact_if;
  logic [1:0]  a;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done;
  logic        busy;

  modport master (
    output a,
    output we,
    output wd,
    input  rd,
    input  done,
    input  busy
  );

  modport slave (
    input  a,
    input  we,
    input  wd,
    output rd,
    output done,
    output busy
  );
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator.
// One 32x4 multiply and one decrement per cycle in MULT.
module fact_accel #(
  parameter int MAX_N = 12
) (
  input logic   clk,
  input logic   rst,
  fact_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MULT = 1'b1;

  localparam logic [1:0] A_N      = 2'd0;
  localparam logic [1:0] A_GO     = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_RESULT = 2'd3;

  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  logic [0:0]  r_state;
  logic [3:0]  r_n;
  logic [3:0]  r_cnt;
  logic [31:0] r_prod;
  logic [31:0] r_result;
  logic        r_done;
  logic        r_err;

  logic        w_wr_n;
  logic        w_go;
  logic        w_n_ok;
  logic        w_busy;
  logic        w_more;
  logic [31:0] w_mul;
  logic        w_unused;

  assign w_wr_n = bus.we && (bus.a == A_N);
  assign w_go   = bus.we && (bus.a == A_GO)
                  && bus.wd[0];
  assign w_n_ok = (r_n <= MAX_N4);
  assign w_busy = (r_state == S_MULT);
  assign w_more = (r_cnt > 4'd1);
  assign w_mul  = r_prod * {28'd0, r_cnt};

  assign w_unused = ^bus.wd[31:4];

  // Operand register; may change mid-job without effect on cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n <= 4'd0;
    end else if (w_wr_n) begin
      r_n <= bus.wd[3:0];
    end
  end

  // Control FSM plus multiply/decrement datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_prod   <= 32'd1;
      r_result <= 32'd0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go && w_n_ok) begin
            r_cnt   <= r_n;
            r_prod  <= 32'd1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_MULT;
          end else if (w_go) begin
            r_err    <= 1'b1;
            r_done   <= 1'b1;
            r_result <= 32'd0;
          end
        end
        S_MULT: begin
          if (w_more) begin
            r_prod <= w_mul;
            r_cnt  <= r_cnt - 4'd1;
          end else begin
            r_result <= r_prod;
            r_done   <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational read mux; returns pre-edge values.
  always_comb begin
    bus.rd = 32'd0;
    unique case (bus.a)
      A_N:      bus.rd = {28'd0, r_n};
      A_GO:     bus.rd = {31'd0, w_busy};
      A_STATUS: bus.rd = {30'd0, r_err, r_done};
      A_RESULT: bus.rd = r_result;
      default:  bus.rd = 32'd0;
    endcase
  end

  assign bus.done = r_done;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_fact_accel.sv
// Directed bench for fact_accel.
// Expected values are hand-computed factorials.
module tb_fact_accel;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fact_if bus ();

  fact_accel #(
    .MAX_N (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic rdchk(
    input string       tag,
    input logic [1:0]  addr,
    input logic [31:0] exp
  );
    bus.a = addr;
    #1;
    chk(tag, bus.rd, exp);
  endtask

  task automatic wr(
    input logic [1:0]  addr,
    input logic [31:0] data
  );
    @(negedge clk);
    bus.a  = addr;
    bus.we = 1'b1;
    bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.wd = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_run(
    input string       tag,
    input logic [31:0] n,
    input logic [31:0] expres,
    input int          lat
  );
    wr(2'd0, n);
    wr(2'd1, 32'd1);
    chk({tag, "_busy_e0"}, {31'd0, bus.busy}, 1);
    chk({tag, "_done_e0"}, {31'd0, bus.done}, 0);
    for (int k = 1; k < lat; k++) begin
      tick();
      chk({tag, "_busy_mid"}, {31'd0, bus.busy}, 1);
      chk({tag, "_done_mid"}, {31'd0, bus.done}, 0);
    end
    tick();
    chk({tag, "_busy_end"}, {31'd0, bus.busy}, 0);
    chk({tag, "_done_end"}, {31'd0, bus.done}, 1);
    rdchk({tag, "_result"}, 2'd3, expres);
    rdchk({tag, "_status"}, 2'd2, 32'h1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    bus.a  = 2'd0;
    bus.we = 1'b0;
    bus.wd = 32'd0;

    #12;
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    rdchk("rst_rd_n", 2'd0, 0);
    rdchk("rst_rd_go", 2'd1, 0);
    rdchk("rst_rd_status", 2'd2, 0);
    rdchk("rst_rd_result", 2'd3, 0);

    go_run("n5", 32'hFFFF_FFF5, 32'd120, 5);
    rdchk("n5_nread", 2'd0, 32'd5);

    go_run("n12", 32'd12, 32'h1C8C_FC00, 12);
    go_run("n0", 32'd0, 32'd1, 1);
    go_run("n1", 32'd1, 32'd1, 1);

    wr(2'd0, 32'd13);
    wr(2'd1, 32'd1);
    chk("err_busy_e0", {31'd0, bus.busy}, 0);
    rdchk("err_status", 2'd2, 32'h3);
    rdchk("err_result", 2'd3, 32'd0);
    tick();
    chk("err_busy_e1", {31'd0, bus.busy}, 0);
    tick();
    chk("err_busy_e2", {31'd0, bus.busy}, 0);
    go_run("n3", 32'd3, 32'd6, 3);

    wr(2'd1, 32'd2);
    chk("go0_busy", {31'd0, bus.busy}, 0);
    rdchk("go0_status", 2'd2, 32'h1);

    wr(2'd0, 32'd6);
    wr(2'd1, 32'd1);
    tick();
    wr(2'd0, 32'd2);
    rdchk("mid_rd_go", 2'd1, 32'd1);
    wr(2'd1, 32'd1);
    chk("mid_busy_e3", {31'd0, bus.busy}, 1);
    tick();
    tick();
    chk("mid_busy_e5", {31'd0, bus.busy}, 1);
    chk("mid_done_e5", {31'd0, bus.done}, 0);
    tick();
    chk("mid_done_e6", {31'd0, bus.done}, 1);
    chk("mid_busy_e6", {31'd0, bus.busy}, 0);
    rdchk("mid_result", 2'd3, 32'd720);
    rdchk("mid_nread", 2'd0, 32'd2);
    rdchk("mid_status", 2'd2, 32'h1);

    wr(2'd1, 32'd1);
    tick();
    wr(2'd1, 32'd1);
    chk("edge_done", {31'd0, bus.done}, 1);
    chk("edge_busy", {31'd0, bus.busy}, 0);
    rdchk("edge_result", 2'd3, 32'd2);

    wr(2'd0, 32'd7);
    wr(2'd1, 32'd1);
    tick();
    tick();
    tick();
    chk("rst7_busy_pre", {31'd0, bus.busy}, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst7_busy", {31'd0, bus.busy}, 0);
    chk("rst7_done", {31'd0, bus.done}, 0);
    rdchk("rst7_rd_n", 2'd0, 0);
    rdchk("rst7_rd_status", 2'd2, 0);
    rdchk("rst7_rd_result", 2'd3, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("rst7_busy_post", {31'd0, bus.busy}, 0);
    chk("rst7_done_post", {31'd0, bus.done}, 0);
    rdchk("rst7_result_post", 2'd3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
